// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: loads a word, shifts it MSB-first into a Moore
// "0001" recognizer, and collects match count and first position.
module seq_scan_ctrl #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned CW = $clog2(WIDTH + 1),
  localparam int unsigned PW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    match_count,
  output logic             found,
  output logic [PW-1:0]    first_pos,
  output logic             det_reset,
  output logic             det_seq_in,
  input  logic             det_match
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [PW-1:0]    idx;

  // Scan FSM; every output is a register updated for the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      sr          <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
      found       <= 1'b0;
      first_pos   <= '0;
      det_reset   <= 1'b1;
      det_seq_in  <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      det_reset  <= 1'b1;
      det_seq_in <= 1'b0;
      if (busy) begin
        match_count <= '0;
        found       <= 1'b0;
        first_pos   <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          det_reset  <= 1'b1;
          det_seq_in <= 1'b0;
          if (start) begin
            state       <= S_CLEAR;
            sr          <= data_in;
            busy        <= 1'b1;
            match_count <= '0;
            found       <= 1'b0;
            first_pos   <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_CLEAR: begin
          state      <= S_SHIFT;
          idx        <= '0;
          det_reset  <= 1'b0;
          det_seq_in <= sr[WIDTH-1];
          sr         <= {sr[WIDTH-2:0], 1'b0};
        end
        S_SHIFT: begin
          if (det_match && idx != '0) begin
            match_count <= match_count + CW'(1);
            if (!found) begin
              found     <= 1'b1;
              first_pos <= idx - PW'(1);
            end
          end
          if (idx == LAST) begin
            state      <= S_DRAIN;
            det_seq_in <= 1'b0;
          end else begin
            idx        <= idx + PW'(1);
            det_seq_in <= sr[WIDTH-1];
            sr         <= {sr[WIDTH-2:0], 1'b0};
          end
        end
        S_DRAIN: begin
          if (det_match) begin
            match_count <= match_count + CW'(1);
            if (!found) begin
              found     <= 1'b1;
              first_pos <= LAST;
            end
          end
          state      <= S_DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
          det_reset  <= 1'b1;
          det_seq_in <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          det_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Sequencer for the Moore "0001" string recognizer. It accepts a parallel WIDTH-bit word on a start strobe, clears the recognizer, shifts the word into it serially MSB-first, samples its match output with the correct one-cycle Moore latency, and reports the match count and the position of the first match. It sits between the word-level host logic and the bit-serial recognizer instance.

## Interface
- WIDTH, 16, bits per scanned word; legal range ≥ 4
- CW, $clog2(WIDTH+1), derived; width of match_count
- PW, $clog2(WIDTH), derived; width of first_pos

- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  request scan of data_in; sampled in IDLE or DONE only
- abort  in  1  cancel a scan in progress; priority over start
- data_in  in  WIDTH  word to scan; captured on the accepting edge
- busy  out  1  high in CLEAR, SHIFT, DRAIN
- done  out  1  one-cycle pulse in DONE
- match_count  out  CW  number of matches in the last completed scan
- found  out  1  at least one match in the last completed scan
- first_pos  out  PW  bit index (0 = MSB) ending the first match; 0 when found=0
- det_reset  out  1  recognizer reset; drives the recognizer's reset
- det_seq_in  out  1  serial bit to the recognizer
- det_match  in  1  recognizer output (Moore, state-decoded)

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE. All outputs decode from registered state and registers.
- IDLE: det_reset=1, det_seq_in=0. On start=1 and abort=0: capture data_in into the shift register, clear match_count, found and first_pos, then go to CLEAR.
- CLEAR: one cycle. det_reset=1, which guarantees the recognizer is in its reset state at the next edge. Then go to SHIFT with bit index i=0.
- SHIFT: det_reset=0. det_seq_in = data[WIDTH-1-i]. i increments each cycle. After i=WIDTH-1, go to DRAIN.
- DRAIN: one cycle, det_seq_in=0. This cycle exists only to observe the recognizer's response to the last bit.
- Match sampling: in SHIFT cycle i≥1 and in DRAIN (treated as i=WIDTH), det_match=1 means a match ends at bit i-1.
  - Each such cycle increments match_count.
  - On the first one, set found=1 and first_pos=i-1.
  - det_match in SHIFT cycle 0 is ignored.
- DONE: done=1 and busy=0; det_reset=1.
  - start=1 here is accepted exactly as in IDLE (back-to-back scans).
  - Otherwise go to IDLE.
- Results hold from DONE until the next accepted start.
- abort=1 in CLEAR/SHIFT/DRAIN: go to IDLE at the next edge, no done pulse, match_count/found/first_pos cleared to 0.
- start while busy is ignored.
- start and abort together in IDLE/DONE: abort wins and the block stays or goes to IDLE.
- match_count cannot overflow; CW covers WIDTH.

## Timing
- Reset values: state IDLE, busy 0, done 0, match_count 0, found 0, first_pos 0, det_reset 1, det_seq_in 0, shift register 0.
- reset mid-scan: all reset values apply in the cycle after the reset edge.
- Let start be accepted at edge E0. Then:
  - CLEAR occupies E0–E1.
  - SHIFT cycle i occupies E(1+i)–E(2+i).
  - DRAIN occupies E(W+1)–E(W+2).
  - done is high from E(W+2) to E(W+3).
- Latency from the start edge to done: WIDTH+2 cycles (18 for WIDTH=16).
- Back-to-back throughput: one scan per WIDTH+3 cycles.
- The recognizer consumes det_seq_in at the edge ending each SHIFT cycle. det_match reflects that bit during the following cycle.

## Test plan
- data_in=16'h1111 → done 18 cycles after start; match_count=4, found=1, first_pos=3. det_seq_in sequence is 0001000100010001.
- data_in=16'hFFFF, then 16'h0000 → match_count=0, found=0, first_pos=0 for both.
- data_in=16'h0001 → match_count=1, first_pos=15; the match is detected in the DRAIN cycle.
- start with 16'h1111, hold start high through busy, assert start again in the DONE cycle with 16'h0F0F → first scan reports 4/3. The second scan begins with no IDLE cycle and reports match_count=2, first_pos=4. Start pulses during busy have no effect.
- abort in SHIFT cycle 5, then start with 16'h1000 → no done for the aborted scan; outputs are 0 after the abort. The second scan reports match_count=1, first_pos=3.
- reset asserted in SHIFT cycle 7 → next cycle shows all reset values with det_reset=1. A following scan of 16'h1111 gives 4/3.
